baud_div_prog: RTL and testbench

//  Runtime-programmable clock/tick divider for the RS422 UART path; generalised successor of the fixed 32:1 divider.

---
 rtl/baud_div_prog_if.sv | 24 ++
 rtl/baud_div_prog.sv | 104 ++++++++++
 tb/tb_baud_div_prog.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/baud_div_prog_if.sv
// Control/strobe bundle for the programmable baud divider.
// The master drives the controls and the slave returns the divided outputs.
interface baud_div_prog_if #(
  parameter int unsigned DIV_W = 12
);
  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] div_val;
  logic             resync;
  logic             clk_out;
  logic             os_tick;
  logic             bit_tick;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output en, div_load, div_val, resync,
    input  clk_out, os_tick, bit_tick, cur_div
  );

  modport slave (
    input  en, div_load, div_val, resync,
    output clk_out, os_tick, bit_tick, cur_div
  );
endinterface

// File: rtl/baud_div_prog.sv
// Runtime-programmable divider for clk59m: divided clock, oversample strobe and bit strobe.
// A new divisor takes effect only at a period boundary, or at once while the divider is idle.
module baud_div_prog #(
  parameter int unsigned DIV_W   = 12,
  parameter int unsigned DEF_DIV = 32,
  parameter int unsigned OVS     = 16,
  parameter int unsigned OVS_W   = 5
) (
  input  logic            clk59m,
  input  logic            rst,
  baud_div_prog_if.slave  bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [OVS_W-1:0] os_cnt_q, os_cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;

  logic [DIV_W-1:0] val_clamp;
  logic [DIV_W:0]   hi;
  logic             at_zero;
  logic             wrap;

  always_comb begin
    val_clamp = (bus.div_val < DIV_W'(2)) ? DIV_W'(2) : bus.div_val;
    hi        = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    at_zero   = (cnt_q == '0);
    wrap      = (cnt_q == div_q - DIV_W'(1));

    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    os_cnt_d   = os_cnt_q;
    clk_out_d  = 1'b0;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;

    if (!bus.en) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      if (bus.div_load) begin
        div_d  = val_clamp;
        pend_d = val_clamp;
      end
    end else begin
      // Outputs decode the current count, so they trail cnt by one cycle.
      clk_out_d  = ({1'b0, cnt_q} < hi);
      os_tick_d  = at_zero;
      bit_tick_d = at_zero && (os_cnt_q == '0);

      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      if (at_zero)
        os_cnt_d = (os_cnt_q == OVS_W'(OVS - 1)) ? '0 : os_cnt_q + OVS_W'(1);

      // Wrap consumes the old pending value; a load on the same cycle re-arms it.
      if (wrap && pend_vld_q) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
      if (bus.div_load) begin
        pend_d     = val_clamp;
        pend_vld_d = 1'b1;
      end

      if (bus.resync) begin
        cnt_d    = '0;
        os_cnt_d = OVS_W'(OVS / 2);
      end
    end
  end

  always_ff @(posedge clk59m or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_q      <= DIV_W'(DEF_DIV);
      pend_q     <= DIV_W'(DEF_DIV);
      pend_vld_q <= 1'b0;
      os_cnt_q   <= '0;
      clk_out_q  <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      os_cnt_q   <= os_cnt_d;
      clk_out_q  <= clk_out_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.cur_div  = div_q;

endmodule

// File: tb/tb_baud_div_prog.sv
// Bench for baud_div_prog: directed scenarios plus random traffic against a
// period/phase reference model kept in plain integers.
module tb_baud_div_prog;
  localparam int unsigned DIV_W   = 12;
  localparam int unsigned DEF_DIV = 32;
  localparam int unsigned OVS     = 16;

  logic clk59m = 1'b0;
  logic rst    = 1'b1;

  baud_div_prog_if #(.DIV_W(DIV_W)) bus ();

  baud_div_prog #(
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV),
    .OVS    (OVS),
    .OVS_W  (5)
  ) dut (
    .clk59m(clk59m),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk59m = ~clk59m;

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the current period, divisor in effect,
  // pending divisor, and running count of oversample ticks for bit alignment.
  int m_pos, m_D, m_pend, m_osn;
  bit m_pv;
  int e_clk, e_os, e_bit;
  int n_os, n_bit;

  function automatic int clamp2(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_D = DEF_DIV; m_pend = DEF_DIV; m_pv = 0; m_osn = 0;
    e_clk = 0; e_os = 0; e_bit = 0;
  endfunction

  function automatic void model_edge();
    bit last;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!bus.en) begin
      e_clk = 0; e_os = 0; e_bit = 0;
      m_pos = 0; m_osn = 0;
      if (bus.div_load) begin
        m_D    = clamp2(int'(bus.div_val));
        m_pend = m_D;
      end
      return;
    end
    e_clk = (m_pos < (m_D + 1) / 2) ? 1 : 0;
    e_os  = (m_pos == 0) ? 1 : 0;
    e_bit = (e_os == 1 && (m_osn % OVS) == 0) ? 1 : 0;
    if (e_os == 1) m_osn++;
    last = (m_pos == m_D - 1);
    if (last && m_pv) begin
      m_D  = m_pend;
      m_pv = 0;
    end
    if (bus.div_load) begin
      m_pend = clamp2(int'(bus.div_val));
      m_pv   = 1;
    end
    m_pos = last ? 0 : m_pos + 1;
    if (bus.resync) begin
      m_pos = 0;
      m_osn = OVS / 2;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("clk_out",  int'(bus.clk_out),  e_clk);
    chk("os_tick",  int'(bus.os_tick),  e_os);
    chk("bit_tick", int'(bus.bit_tick), e_bit);
    chk("cur_div",  int'(bus.cur_div),  m_D);
  endtask

  task automatic step();
    @(posedge clk59m);
    model_edge();
    #1;
    check_outputs();
    if (bus.os_tick === 1'b1)  n_os++;
    if (bus.bit_tick === 1'b1) n_bit++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v);
    bus.div_load = 1'b1;
    bus.div_val  = DIV_W'(v);
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic pulse_resync();
    bus.resync = 1'b1;
    step();
    bus.resync = 1'b0;
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 5000 && m_pos != p; i++) step();
    chk("reach_pos", m_pos, p);
  endtask

  initial begin
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0; bus.resync = 1'b0;
    model_reset();

    // Power-on reset
    #2 rst = 1'b0;
    #1 check_outputs();
    #20 rst = 1'b1;
    bus.en = 1'b1;

    // Default divisor: 16 high / 16 low, os_tick every 32, bit_tick every 512
    n_os = 0; n_bit = 0;
    run(1100);
    chk("n_os_default",  n_os,  35);
    chk("n_bit_default", n_bit, 3);

    // Divisor 7 requested mid-period
    run_to_pos(10);
    load(7);
    chk("div_hold_32", int'(bus.cur_div), 32);
    run(40);
    chk("div_now_7", int'(bus.cur_div), 7);

    // Clamp of 1 and 0 to 2
    load(1);
    load(0);
    run(20);
    chk("div_clamp_2", int'(bus.cur_div), 2);
    load(32);
    run(10);

    // Resync at arbitrary phase, then watch bit realignment
    run_to_pos(13);
    pulse_resync();
    n_os = 0; n_bit = 0;
    run(600);
    chk("n_bit_resync", n_bit, 1);

    // Resync exactly on the wrap cycle with a pending divisor
    run_to_pos(25);
    load(9);
    run_to_pos(31);
    pulse_resync();
    chk("div_wrap_resync", int'(bus.cur_div), 9);
    run(40);
    load(32);
    run(40);

    // Asynchronous reset mid-period
    run_to_pos(20);
    #3 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    run(3);
    #2 rst = 1'b1;
    n_os = 0; n_bit = 0;
    run(600);
    chk("n_bit_after_rst", n_bit, 2);

    // Idle load applies immediately
    bus.en = 1'b0;
    run(50);
    load(100);
    chk("div_idle_100", int'(bus.cur_div), 100);
    bus.en = 1'b1;
    run(250);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.en       = ($urandom_range(0, 19) != 0);
      bus.div_load = ($urandom_range(0, 39) == 0);
      bus.div_val  = DIV_W'($urandom_range(0, 24));
      bus.resync   = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.en = 1'b1; bus.div_load = 1'b0; bus.resync = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
